// File: rtl/gauss_pkg.sv
// Shared types and default geometry for the Gaussian window sequencer.
package gauss_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } gauss_state_t;

    localparam int LINE_W_DEF  = 640;
    localparam int FRAME_H_DEF = 480;
    localparam int ROWS_DEF    = 6;
    localparam int AW_DEF      = 10;
    localparam int POS_W       = 13;

endpackage

// File: rtl/gauss_col_ctr.sv
// Column / RAM address counter with compare-based wrap at LINE_W-1.
// clr forces the current position to column 0 so a pixel arriving with clr lands at address 0.
module gauss_col_ctr
    import gauss_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEF,
    parameter int AW     = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          adv,
    output logic [12:0]   col,
    output logic [AW-1:0] wr_adr,
    output logic [AW-1:0] rd_adr,
    output logic          line_end
);

    localparam logic [12:0]   LAST    = 13'(LINE_W - 1);
    localparam logic [AW-1:0] RD_INIT = (LINE_W == 1) ? '0 : AW'(1);

    logic [12:0]   col_q;
    logic [12:0]   col_n;
    logic [12:0]   base;
    logic [AW-1:0] rd_q;
    logic [AW-1:0] rd_n;

    always_comb begin
        base     = clr ? '0 : col_q;
        line_end = adv && (base == LAST);
        col_n    = base;
        if (adv) begin
            col_n = line_end ? '0 : base + 13'd1;
        end
        // read-ahead address is kept registered alongside col
        rd_n = (col_n == LAST) ? '0 : AW'(col_n + 13'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            rd_q  <= RD_INIT;
        end else begin
            col_q <= col_n;
            rd_q  <= rd_n;
        end
    end

    assign col    = base;
    assign wr_adr = base[AW-1:0];
    assign rd_adr = clr ? RD_INIT : rd_q;

endmodule

// File: rtl/gauss_window_seq.sv
// Line-buffer window sequencer: position tracking, row priming mask and frame control.
// Define GAUSS_WIN_DRAIN_EN to flush the last ROWS-1 window lines with zero pixels.
module gauss_window_seq
    import gauss_pkg::*;
#(
    parameter int LINE_W  = LINE_W_DEF,
    parameter int FRAME_H = FRAME_H_DEF,
    parameter int ROWS    = ROWS_DEF,
    parameter int AW      = AW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sof,
    input  logic            pix_valid,
    output logic [12:0]     col,
    output logic [12:0]     line,
    output logic [AW-1:0]   wr_adr,
    output logic [AW-1:0]   rd_adr,
    output logic [ROWS-1:0] row_shift_en,
    output logic            pix_zero,
    output logic            win_valid,
    output logic            frame_done
);

    localparam logic [12:0] PRIME_LAST = 13'(ROWS - 2);
    localparam logic [12:0] IN_LAST    = 13'(FRAME_H - 1);
    localparam logic [12:0] LINE_CAP   = 13'(FRAME_H + ROWS - 2);

    gauss_state_t    state;
    gauss_state_t    state_n;
    logic [12:0]     line_q;
    logic [12:0]     line_n;
    logic [12:0]     line_base;
    logic [ROWS-1:0] m;
    logic [ROWS-1:0] m_n;
    logic [ROWS-1:0] m_eff;
    logic            adv;
    logic            line_end;
    logic            done;

    // sof overrides the current state, so a pixel arriving with it is counted as in PRIME
    always_comb begin
        adv = 1'b0;
        if (sof) begin
            adv = pix_valid;
        end else begin
            case (state)
                PRIME, RUN: adv = pix_valid;
                DRAIN:      adv = 1'b1;
                default:    adv = 1'b0;
            endcase
        end
    end

    gauss_col_ctr #(
        .LINE_W (LINE_W),
        .AW     (AW)
    ) u_col_ctr (
        .clk      (clk),
        .rst      (rst),
        .clr      (sof),
        .adv      (adv),
        .col      (col),
        .wr_adr   (wr_adr),
        .rd_adr   (rd_adr),
        .line_end (line_end)
    );

    always_comb begin
        line_base = sof ? '0 : line_q;
        line_n    = line_base;
        if (line_end) begin
            line_n = (line_base >= LINE_CAP) ? LINE_CAP : line_base + 13'd1;
        end

        m_n = sof ? ROWS'(1) : m;
        if (line_end && !sof) begin
            for (int k = 1; k < ROWS; k++) begin
                if (line_q == 13'(k - 1)) begin
                    m_n[k] = 1'b1;
                end
            end
        end

        state_n = state;
        done    = 1'b0;
        if (sof) begin
            state_n = PRIME;
        end else begin
            case (state)
                PRIME: begin
                    if (line_end && line_q == PRIME_LAST) state_n = RUN;
                end
                RUN: begin
                    if (line_end && line_q == IN_LAST) begin
`ifdef GAUSS_WIN_DRAIN_EN
                        state_n = DRAIN;
`else
                        state_n = IDLE;
                        done    = 1'b1;
`endif
                    end
                end
                DRAIN: begin
                    if (line_end && line_q == LINE_CAP) begin
                        state_n = IDLE;
                        done    = 1'b1;
                    end
                end
                default: state_n = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            line_q <= '0;
            m      <= '0;
        end else begin
            state  <= state_n;
            line_q <= line_n;
            m      <= m_n;
        end
    end

    assign m_eff        = sof ? ROWS'(1) : m;
    assign row_shift_en = m_eff & {ROWS{adv}};
    assign win_valid    = adv && !sof && (state == RUN || state == DRAIN);
    assign line         = line_base;
    assign frame_done   = done;
`ifdef GAUSS_WIN_DRAIN_EN
    assign pix_zero     = !sof && (state == DRAIN);
`else
    assign pix_zero     = 1'b0;
`endif

endmodule

// File: tb/tb_gauss_window_seq.sv
// Randomized bench for gauss_window_seq against a pixel-index reference model.
module tb_gauss_window_seq;

    localparam int LW    = 8;
    localparam int FH    = 10;
    localparam int RW    = 6;
    localparam int AWB   = 10;
    localparam int TOTIN = LW * FH;
    localparam int CAP   = FH + RW - 2;
`ifdef GAUSS_WIN_DRAIN_EN
    localparam bit DRN   = 1'b1;
    localparam int TOT   = LW * (FH + RW - 1);
`else
    localparam bit DRN   = 1'b0;
    localparam int TOT   = TOTIN;
`endif

    logic            clk;
    logic            rst;
    logic            sof;
    logic            pix_valid;
    logic [12:0]     col;
    logic [12:0]     line;
    logic [AWB-1:0]  wr_adr;
    logic [AWB-1:0]  rd_adr;
    logic [RW-1:0]   row_shift_en;
    logic            pix_zero;
    logic            win_valid;
    logic            frame_done;

    gauss_window_seq #(
        .LINE_W  (LW),
        .FRAME_H (FH),
        .ROWS    (RW),
        .AW      (AWB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sof          (sof),
        .pix_valid    (pix_valid),
        .col          (col),
        .line         (line),
        .wr_adr       (wr_adr),
        .rd_adr       (rd_adr),
        .row_shift_en (row_shift_en),
        .pix_zero     (pix_zero),
        .win_valid    (win_valid),
        .frame_done   (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nbad = 0;

    // reference model: frame position as a flat pixel index
    int p      = 0;
    bit active = 1'b0;
    bit seen_wv;
    bit seen_fd;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nbad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit s, input bit v);
        int  ec, el, erd, ersh, filled;
        bit  ewv, epz, efd, eadv, drn;
        sof       = s;
        pix_valid = v;
        @(negedge clk);
        ewv = 0; epz = 0; efd = 0; eadv = 0; ersh = 0;
        if (s) begin
            ec = 0; el = 0; erd = 1 % LW;
            eadv = v;
            ersh = v ? 1 : 0;
        end else begin
            ec  = p % LW;
            el  = (p / LW > CAP) ? CAP : p / LW;
            erd = (ec + 1) % LW;
            if (active) begin
                drn    = DRN && (p >= TOTIN);
                eadv   = drn || v;
                filled = (el + 1 > RW) ? RW : el + 1;
                ersh   = eadv ? ((1 << filled) - 1) : 0;
                ewv    = eadv && (el >= RW - 1);
                epz    = drn;
                efd    = eadv && (p == TOT - 1);
            end
        end
        check_val("col", 32'(col), 32'(ec));
        check_val("line", 32'(line), 32'(el));
        check_val("wr_adr", 32'(wr_adr), 32'(ec));
        check_val("rd_adr", 32'(rd_adr), 32'(erd));
        check_val("row_shift_en", 32'(row_shift_en), 32'(ersh));
        check_val("win_valid", 32'(win_valid), 32'(ewv));
        check_val("pix_zero", 32'(pix_zero), 32'(epz));
        check_val("frame_done", 32'(frame_done), 32'(efd));
        seen_wv = win_valid;
        seen_fd = frame_done;
        @(posedge clk);
        if (s) begin
            p      = v ? 1 : 0;
            active = 1'b1;
        end else if (active && eadv) begin
            p++;
            if (p == TOT) active = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset(input bit with_sof);
        rst       = 1'b1;
        sof       = with_sof;
        pix_valid = with_sof;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        p      = 0;
        active = 1'b0;
    endtask

    initial begin
        int first_wv;
        int fd_cnt;
        rst = 1'b1; sof = 1'b0; pix_valid = 1'b0;
        do_reset(1'b0);

        // pixels without sof are ignored in IDLE
        repeat (4) step(1'b0, 1'b1);

        // one full frame of continuous pixels, then drain/idle
        step(1'b1, 1'b0);
        first_wv = -1;
        fd_cnt   = 0;
        for (int i = 0; i < TOTIN; i++) begin
            step(1'b0, 1'b1);
            if (seen_wv && first_wv < 0) first_wv = i;
            if (seen_fd) fd_cnt++;
        end
        for (int i = 0; i < LW * RW + 4; i++) begin
            step(1'b0, 1'b0);
            if (seen_fd) fd_cnt++;
        end
        check_val("first_wv_pix", 32'(first_wv), 32'(LW * (RW - 1)));
        check_val("frame_done_cnt", 32'(fd_cnt), 32'd1);

        // sof together with a pixel in the middle of line 3
        step(1'b1, 1'b1);
        repeat (3 * LW + 3) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b1);

        // reset wins over a simultaneous sof
        do_reset(1'b1);
        repeat (3) step(1'b0, 1'b1);

        // random traffic with occasional restarts
        step(1'b1, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 7));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
